// File: rtl/spi_ram_arbiter_if.sv
// spi_ram_arbiter_if: requester-side bus of spi_ram_arbiter.
// Signals: req_valid/req_we/req_addr0/req_addr1/req_wdata0/req_wdata1 carry requests,
// req_ready acknowledges them, and rsp_valid/rsp_id/rsp_rdata return completions.
// The master modport is the requester side. The slave modport is the arbiter side.
interface spi_ram_arbiter_if #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
);
    logic [1:0]           req_valid;
    logic [1:0]           req_we;
    logic [1:0]           req_ready;
    logic [ADDR_SIZE-1:0] req_addr0;
    logic [ADDR_SIZE-1:0] req_addr1;
    logic [DATA_SIZE-1:0] req_wdata0;
    logic [DATA_SIZE-1:0] req_wdata1;
    logic                 rsp_valid;
    logic                 rsp_id;
    logic [DATA_SIZE-1:0] rsp_rdata;
    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_id, rsp_rdata
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: two-port round-robin arbiter and command sequencer in front of spi_ram.
// Ports: clk, rst (async, active-high). bus (spi_ram_arbiter_if.slave) carries requests and
// completions. busy is high whenever a transaction is in flight. ram_din/ram_rx_valid drive the
// RAM command port. ram_dout supplies the read data. ram_tx_valid is monitored only.
// Optional macro SPI_ARB_ADDR_CACHE_EN skips the ADDR word when the address matches the
// last address sent to the RAM.
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_ram_arbiter_if.slave bus,
    output logic             busy,
    output logic [9:0]       ram_din,
    output logic             ram_rx_valid,
    input  logic [7:0]       ram_dout,
    input  logic             ram_tx_valid
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RDCAP} state_t;
    state_t               state;
    logic                 last, id, we, grant, accept, sel_we, hit, unused_tx;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [DATA_SIZE-1:0] wdata, sel_wdata;
    assign unused_tx = ram_tx_valid;
    // A lone requester wins. On a tie, the port not served last wins.
    assign grant         = &bus.req_valid ? ~last : bus.req_valid[1];
    assign accept        = (state == IDLE) && |bus.req_valid;
    assign bus.req_ready = {accept && grant, accept && !grant};
    assign sel_we        = bus.req_we[grant];
    assign sel_addr      = grant ? bus.req_addr1 : bus.req_addr0;
    assign sel_wdata     = grant ? bus.req_wdata1 : bus.req_wdata0;
`ifdef SPI_ARB_ADDR_CACHE_EN
    logic                 cache_vld;
    logic [ADDR_SIZE-1:0] cache_addr;
    assign hit = cache_vld && cache_addr == sel_addr;
    // The ADDR word is loaded at the accept edge. Reset clears the cache if ADDR never completes.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cache_vld  <= 1'b0;
            cache_addr <= '0;
        end else if (accept && !hit) begin
            cache_vld  <= 1'b1;
            cache_addr <= sel_addr;
        end
`else
    assign hit = 1'b0;
`endif
    // Each output is loaded with the value for the state being entered, so outputs stay registered.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= IDLE;
            last          <= 1'b1;
            id            <= 1'b0;
            we            <= 1'b0;
            wdata         <= '0;
            busy          <= 1'b0;
            ram_rx_valid  <= 1'b0;
            ram_din       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    id           <= grant;
                    last         <= grant;
                    we           <= sel_we;
                    wdata        <= sel_wdata;
                    busy         <= 1'b1;
                    ram_rx_valid <= 1'b1;
                    state        <= hit ? DATA : ADDR;
                    ram_din      <= hit ? (sel_we ? {2'b01, sel_wdata} : 10'h300)
                                        : {sel_we ? 2'b00 : 2'b10, sel_addr};
                end
                ADDR: begin
                    state   <= DATA;
                    ram_din <= we ? {2'b01, wdata} : 10'h300;
                end
                DATA: begin
                    ram_rx_valid  <= 1'b0;
                    ram_din       <= '0;
                    state         <= we ? IDLE : RDCAP;
                    busy          <= !we;
                    bus.rsp_valid <= we;
                    bus.rsp_id    <= we ? id : bus.rsp_id;
                end
                RDCAP: begin
                    // ram_dout was loaded by the read command on the edge that ended DATA.
                    state         <= IDLE;
                    busy          <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_id    <= id;
                    bus.rsp_rdata <= ram_dout;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: randomized and directed checks of spi_ram_arbiter against a transaction-level model.
module tb_spi_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_ram_arbiter_if #(.ADDR_SIZE(8), .DATA_SIZE(8)) bus();
    logic       busy, ram_rx_valid;
    logic       ram_tx_valid = 1'b0;
    logic [9:0] ram_din;
    logic [7:0] ram_dout = 8'h00;

    spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .ram_din(ram_din),
        .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    // spi_ram behaviour: one shared address register. Command 11 loads dout.
    logic [7:0] ram_mem [256] = '{default: 8'h00};
    logic [7:0] ram_areg = 8'h00;
    always @(posedge clk)
        if (ram_rx_valid)
            case (ram_din[9:8])
                2'b00, 2'b10: ram_areg <= ram_din[7:0];
                2'b01:        ram_mem[ram_areg] <= ram_din[7:0];
                default: begin
                    ram_dout     <= ram_mem[ram_areg];
                    ram_tx_valid <= 1'b1;
                end
            endcase

    // requesters
    logic [1:0] v = 2'b00, wem = 2'b00;
    logic [7:0] am [2] = '{8'h00, 8'h00};
    logic [7:0] dm [2] = '{8'h00, 8'h00};
    assign bus.req_valid  = v;
    assign bus.req_we     = wem;
    assign bus.req_addr0  = am[0];
    assign bus.req_addr1  = am[1];
    assign bus.req_wdata0 = dm[0];
    assign bus.req_wdata1 = dm[1];

    // Transaction-level model: each accept expands into a list of expected busy cycles.
    typedef struct packed {logic rxv; logic [9:0] din;} slot_t;
    slot_t      q[$];
    logic [7:0] mmem [256] = '{default: 8'h00};
    logic       rsp_next, last_m, hold_id, p_id, p_we, cvld;
    logic [7:0] hold_rdata, p_rdata, caddr;
    int         nchk = 0, nfail = 0, cycn = 0, acc_cyc = 0, rsp_cyc = 0;
    logic [9:0] din_log[$];
    int         gnt_log[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cycn);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rsp_next = 1'b0; last_m = 1'b1; hold_id = 1'b0; hold_rdata = 8'h00;
        cvld = 1'b0; caddr = 8'h00; p_id = 1'b0; p_we = 1'b0; p_rdata = 8'h00;
    endtask

    task automatic model_accept(input int g);
        logic hitm;
        hitm = 1'b0;
        last_m = g[0]; p_id = g[0]; p_we = wem[g];
        gnt_log.push_back(g);
        acc_cyc = cycn;
`ifdef SPI_ARB_ADDR_CACHE_EN
        hitm = cvld && caddr == am[g];
        cvld = 1'b1; caddr = am[g];
`endif
        if (!hitm) q.push_back({1'b1, wem[g] ? 2'b00 : 2'b10, am[g]});
        q.push_back({1'b1, wem[g] ? {2'b01, dm[g]} : 10'h300});
        if (wem[g]) mmem[am[g]] = dm[g];
        else begin
            p_rdata = mmem[am[g]];
            q.push_back({1'b0, 10'h000});
        end
    endtask

    // One clock: compare at the falling edge, then let the rising edge consume any accept.
    task automatic cyc();
        slot_t e;
        logic  cb, rv;
        int    g, p;
        @(negedge clk);
        cycn++;
        cb = q.size() > 0;
        e  = '0;
        if (cb) e = q.pop_front();
        rv = rsp_next;
        rsp_next = cb && q.size() == 0;
        if (rv) begin
            hold_id = p_id;
            if (!p_we) hold_rdata = p_rdata;
        end
        g = -1;
        if (!cb)
            for (int k = 0; k < 2; k++) begin
                p = last_m ? k : 1 - k;
                if (g < 0 && v[p]) g = p;
            end
        chk("busy", busy, cb);
        chk("ram_rx_valid", ram_rx_valid, e.rxv);
        chk("ram_din", ram_din, e.din);
        chk("rsp_valid", bus.rsp_valid, rv);
        chk("rsp_id", bus.rsp_id, hold_id);
        chk("rsp_rdata", bus.rsp_rdata, hold_rdata);
        chk("req_ready", bus.req_ready, g == 0 ? 2'b01 : g == 1 ? 2'b10 : 2'b00);
        if (ram_rx_valid) din_log.push_back(ram_din);
        if (bus.rsp_valid) rsp_cyc = cycn;
        if (g >= 0) model_accept(g);
        @(posedge clk);
        #1;
        if (g >= 0) begin
            v[g] = 1'b0; wem[g] = 1'($urandom); am[g] = 8'($urandom); dm[g] = 8'($urandom);
        end
    endtask

    task automatic req(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
        v[k] = 1'b1; wem[k] = w; am[k] = a; dm[k] = d;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((v != 2'b00 || q.size() != 0 || rsp_next) && i < 60) begin
            cyc();
            i++;
        end
        chk("drain_within_bound", i < 60, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk("rst_rx_valid", ram_rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din", ram_din, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);

        // port-0 write 8B <= B6
        din_log.delete();
        req(0, 1'b1, 8'h8B, 8'hB6);
        drain();
        chk("wr_words", din_log.size(), 2);
        chk("wr_addr_word", din_log[0], 10'h08B);
        chk("wr_data_word", din_log[1], 10'h1B6);
        chk("wr_latency", rsp_cyc - acc_cyc, 3);
        chk("wr_rsp_id", bus.rsp_id, 0);

        // port-1 read of 8B
        din_log.delete();
        req(1, 1'b0, 8'h8B, 8'h00);
        drain();
`ifdef SPI_ARB_ADDR_CACHE_EN
        chk("rd_words", din_log.size(), 1);
        chk("rd_data_word", din_log[0], 10'h300);
        chk("rd_latency", rsp_cyc - acc_cyc, 3);
`else
        chk("rd_words", din_log.size(), 2);
        chk("rd_addr_word", din_log[0], 10'h28B);
        chk("rd_data_word", din_log[1], 10'h300);
        chk("rd_latency", rsp_cyc - acc_cyc, 4);
`endif
        chk("rd_rdata", bus.rsp_rdata, 8'hB6);
        chk("rd_rsp_id", bus.rsp_id, 1);

        // continuous contention for four transactions
        gnt_log.delete();
        req(0, 1'($urandom), 8'($urandom), 8'($urandom));
        req(1, 1'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 60 && gnt_log.size() < 4; i++) begin
            cyc();
            if (gnt_log.size() < 3)
                for (int k = 0; k < 2; k++)
                    if (!v[k]) req(k, 1'($urandom), 8'($urandom), 8'($urandom));
        end
        drain();
        chk("contention_count", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("contention_order", gnt_log[i], i % 2);

        // reset during the DATA cycle of a read
        req(0, 1'b0, 8'hC4, 8'h00);
        cyc();
        for (int i = 0; i < 4 && q.size() > 0 && q[0].din != 10'h300; i++) cyc();
        chk("reached_data", q.size() > 0 ? 32'(q[0].din) : 32'h0, 10'h300);
        pulse_reset();
        gnt_log.delete();
        req(0, 1'b1, 8'h21, 8'h5A);
        req(1, 1'b1, 8'h22, 8'hA5);
        drain();
        chk("post_reset_first_grant", gnt_log[0], 0);
        chk("post_reset_second_grant", gnt_log[1], 1);

        // cache behaviour directly after reset and on repeated address
        pulse_reset();
        din_log.delete();
        req(0, 1'b0, 8'h00, 8'h00);
        drain();
        chk("cold_rd_words", din_log.size(), 2);
        chk("cold_rd_addr_word", din_log[0], 10'h200);
        req(1, 1'b1, 8'h0F, 8'h0F);
        drain();
        din_log.delete();
        req(0, 1'b0, 8'h0F, 8'h00);
        drain();
`ifdef SPI_ARB_ADDR_CACHE_EN
        chk("hit_rd_words", din_log.size(), 1);
        chk("hit_rd_latency", rsp_cyc - acc_cyc, 3);
`else
        chk("rd0f_words", din_log.size(), 2);
        chk("rd0f_latency", rsp_cyc - acc_cyc, 4);
`endif
        chk("rd0f_rdata", bus.rsp_rdata, 8'h0F);

        // randomized traffic over a small address set so addresses repeat
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++)
                if (!v[k] && $urandom_range(0, 2) == 0)
                    req(k, 1'($urandom), 8'($urandom_range(0, 7)) + 8'hF0, 8'($urandom));
            cyc();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
